// File: rtl/nonce_scheduler_pkg.sv
// nonce_scheduler_pkg
// Shared types and constants for the nonce scheduler: FSM state encoding,
// header geometry (80-byte header, nonce at bytes 76..79) and a helper that
// builds the leading-zero hit mask for a digest.
package nonce_scheduler_pkg;

  localparam int unsigned HDR_BYTES = 80;
  localparam int unsigned NONCE_OFS = 76;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned HASH_W    = 256;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH_REQ  = 3'd1,
    ST_FETCH_GAP  = 3'd2,
    ST_HASH_START = 3'd3,
    ST_HASH_WAIT  = 3'd4,
    ST_CHECK      = 3'd5,
    ST_FOUND      = 3'd6,
    ST_EXHAUSTED  = 3'd7
  } state_e;

  // Ones in the zero_bits most-significant positions of the digest.
  function automatic logic [HASH_W-1:0] hit_mask(input int unsigned zero_bits);
    return ~({HASH_W{1'b1}} >> zero_bits);
  endfunction

endpackage

// File: rtl/nonce_scheduler_header_buffer.sv
// header_buffer
// 80x8 header register file. Written one byte at a time during the host
// fetch; read combinationally by the hash core. Reads of bytes 76..79 return
// the nonce under test (little-endian) instead of the stored bytes, reads
// beyond byte 79 return 0. The stored base nonce (bytes 76..79) is exported
// so the scheduler can seed its nonce counter after the fetch.
// Ports:
//   clk        in  clock
//   wr_en      in  write strobe
//   wr_addr    in  write byte index
//   wr_data    in  write byte
//   rd_addr    in  read byte index
//   nonce      in  nonce overlaid on bytes 76..79
//   rd_data    out read byte (combinational)
//   base_nonce out stored bytes {79,78,77,76}
module header_buffer
  import nonce_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       nonce,
  output logic [7:0]        rd_data,
  output logic [31:0]       base_nonce
);

  localparam logic [ADDR_W-1:0] NONCE_ADDR = ADDR_W'(NONCE_OFS);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(HDR_BYTES - 1);

  logic [7:0] mem_q [HDR_BYTES];

  // Contents need no reset; every byte is rewritten before a job uses it.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr <= LAST_ADDR)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr > LAST_ADDR) begin
      rd_data = 8'h00;
    end else if (rd_addr >= NONCE_ADDR) begin
      // 76 is 4-aligned, so the low two address bits select the nonce byte.
      case (rd_addr[1:0])
        2'd0:    rd_data = nonce[7:0];
        2'd1:    rd_data = nonce[15:8];
        2'd2:    rd_data = nonce[23:16];
        default: rd_data = nonce[31:24];
      endcase
    end else begin
      rd_data = mem_q[rd_addr];
    end
  end

  assign base_nonce = {mem_q[NONCE_OFS+3], mem_q[NONCE_OFS+2],
                       mem_q[NONCE_OFS+1], mem_q[NONCE_OFS]};

endmodule

// File: rtl/nonce_scheduler.sv
// nonce_scheduler
// Sequences the double-SHA-256 core: fetches the 80-byte header from the
// host byte handshake, then launches one hash per nonce starting at the
// header's own nonce, checking each digest for ZERO_BITS leading zeros.
// Reports the winning nonce, or exhaustion when the nonce wraps to its base.
// Optional build macro NONCE_SCHEDULER_LIMIT_EN adds input max_tries that
// caps the number of missed nonces (0 = unlimited).
// Ports:
//   clk, rst (sync, active-high)
//   start                          begin a job (IDLE/FOUND/EXHAUSTED only)
//   host_rq/host_addr/host_data/host_rdy   header byte fetch handshake
//   core_start/core_nonce/core_addr/core_byte/core_done/core_hash  core i/f
//   busy, found, exhausted, found_nonce    job status
//
// state         | meaning
// IDLE          | no job since reset
// FETCH_REQ     | requesting header byte host_addr
// FETCH_GAP     | one-cycle request gap, advance address
// HASH_START    | pulse core_start for current nonce
// HASH_WAIT     | waiting for core_done, latch digest
// CHECK         | compare digest, pick next nonce
// FOUND         | hit reported, found_nonce valid
// EXHAUSTED     | nonce space (or try budget) used up
module nonce_scheduler
  import nonce_scheduler_pkg::*;
#(
  parameter int unsigned ZERO_BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef NONCE_SCHEDULER_LIMIT_EN
  input  logic [31:0]       max_tries,
`endif
  output logic              host_rq,
  output logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_data,
  input  logic              host_rdy,
  output logic              core_start,
  output logic [31:0]       core_nonce,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [7:0]        core_byte,
  input  logic              core_done,
  input  logic [HASH_W-1:0] core_hash,
  output logic              busy,
  output logic              found,
  output logic              exhausted,
  output logic [31:0]       found_nonce
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HDR_BYTES - 1);
  localparam logic [HASH_W-1:0] HIT_MASK  = hit_mask(ZERO_BITS);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         nonce_q, nonce_d;
  logic [31:0]         base_q, base_d;
  logic [31:0]         found_nonce_q, found_nonce_d;
  logic [HASH_W-1:0]   hash_q, hash_d;
  logic                buf_we;
  logic [31:0]         buf_base;
  logic                hit;
  logic                limit_hit;
`ifdef NONCE_SCHEDULER_LIMIT_EN
  logic [31:0]         tries_q, tries_d;
`endif

  header_buffer u_buf (
    .clk        (clk),
    .wr_en      (buf_we),
    .wr_addr    (addr_q),
    .wr_data    (host_data),
    .rd_addr    (core_addr),
    .nonce      (nonce_q),
    .rd_data    (core_byte),
    .base_nonce (buf_base)
  );

  assign hit = (hash_q & HIT_MASK) == '0;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    nonce_d       = nonce_q;
    base_d        = base_q;
    found_nonce_d = found_nonce_q;
    hash_d        = hash_q;
    buf_we        = 1'b0;
    limit_hit     = 1'b0;
`ifdef NONCE_SCHEDULER_LIMIT_EN
    tries_d       = tries_q;
`endif
    case (state_q)
      ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
        if (start) begin
          state_d       = ST_FETCH_REQ;
          addr_d        = '0;
          found_nonce_d = '0;
        end
      end
      ST_FETCH_REQ: begin
        if (host_rdy) begin
          buf_we  = 1'b1;
          state_d = ST_FETCH_GAP;
        end
      end
      ST_FETCH_GAP: begin
        if (addr_q == LAST_ADDR) begin
          // Byte 79 was written last cycle, so the base is complete here.
          state_d = ST_HASH_START;
          nonce_d = buf_base;
          base_d  = buf_base;
`ifdef NONCE_SCHEDULER_LIMIT_EN
          tries_d = '0;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_FETCH_REQ;
        end
      end
      ST_HASH_START: begin
        state_d = ST_HASH_WAIT;
      end
      ST_HASH_WAIT: begin
        if (core_done) begin
          hash_d  = core_hash;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (hit) begin
          state_d       = ST_FOUND;
          found_nonce_d = nonce_q;
        end else begin
          nonce_d = nonce_q + 32'd1;
`ifdef NONCE_SCHEDULER_LIMIT_EN
          tries_d   = tries_q + 32'd1;
          limit_hit = (max_tries != '0) && (tries_d == max_tries);
`endif
          if ((nonce_d == base_q) || limit_hit) state_d = ST_EXHAUSTED;
          else                                  state_d = ST_HASH_START;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      nonce_q       <= '0;
      base_q        <= '0;
      found_nonce_q <= '0;
      hash_q        <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      nonce_q       <= nonce_d;
      base_q        <= base_d;
      found_nonce_q <= found_nonce_d;
      hash_q        <= hash_d;
    end
  end

`ifdef NONCE_SCHEDULER_LIMIT_EN
  always_ff @(posedge clk) begin
    if (rst) tries_q <= '0;
    else     tries_q <= tries_d;
  end
`endif

  assign host_rq     = (state_q == ST_FETCH_REQ);
  assign host_addr   = addr_q;
  assign core_start  = (state_q == ST_HASH_START);
  assign core_nonce  = nonce_q;
  assign busy        = (state_q == ST_FETCH_REQ)  || (state_q == ST_FETCH_GAP) ||
                       (state_q == ST_HASH_START) || (state_q == ST_HASH_WAIT) ||
                       (state_q == ST_CHECK);
  assign found       = (state_q == ST_FOUND);
  assign exhausted   = (state_q == ST_EXHAUSTED);
  assign found_nonce = found_nonce_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// tb_nonce_scheduler
// Directed bench: host byte responder with varying ready latency, a core
// model with fixed latency that returns a qualifying digest only at one
// chosen nonce, and hand-computed expectations for each job.
module tb_nonce_scheduler;

  localparam int CORE_LAT = 5;
  localparam logic [255:0] HIT_HASH  = {32'h0000_0000, {224{1'b1}}};
  // Only bit 224 set within the top 32 bits: the narrowest possible miss.
  localparam logic [255:0] MISS_HASH = {32'h0000_0001, {224{1'b1}}};

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         host_rq;
  logic [6:0]   host_addr;
  logic [7:0]   host_data;
  logic         host_rdy;
  logic         core_start;
  logic [31:0]  core_nonce;
  logic [6:0]   core_addr;
  logic [7:0]   core_byte;
  logic         core_done;
  logic [255:0] core_hash;
  logic         busy;
  logic         found;
  logic         exhausted;
  logic [31:0]  found_nonce;
`ifdef NONCE_SCHEDULER_LIMIT_EN
  logic [31:0]  max_tries;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  hdr [80];
  logic        hit_en;
  logic [31:0] hit_nonce;
  int          n_start;
  logic [31:0] last_nonce;

  always #5 clk = ~clk;

  nonce_scheduler #(.ZERO_BITS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef NONCE_SCHEDULER_LIMIT_EN
    .max_tries   (max_tries),
`endif
    .host_rq     (host_rq),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .host_rdy    (host_rdy),
    .core_start  (core_start),
    .core_nonce  (core_nonce),
    .core_addr   (core_addr),
    .core_byte   (core_byte),
    .core_done   (core_done),
    .core_hash   (core_hash),
    .busy        (busy),
    .found       (found),
    .exhausted   (exhausted),
    .found_nonce (found_nonce)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Core model: sees core_start at the falling edge, answers CORE_LAT cycles later.
  initial begin
    core_done = 1'b0;
    core_hash = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        n_start++;
        last_nonce = core_nonce;
        repeat (CORE_LAT) @(negedge clk);
        core_hash = (hit_en && (last_nonce == hit_nonce)) ? HIT_HASH : MISS_HASH;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
      end
    end
  end

  task automatic set_header(input logic [31:0] base);
    for (int i = 0; i < 80; i++) hdr[i] = 8'h00;
    hdr[0]  = 8'h01;
    hdr[76] = base[7:0];
    hdr[77] = base[15:8];
    hdr[78] = base[23:16];
    hdr[79] = base[31:24];
  endtask

  // Serves bytes 0..79 with ready latency 1..3; checks order and the gap.
  task automatic fetch_header(input bit poke);
    int errs;
    int lat;
    errs = 0;
    for (int i = 0; i < 80; i++) begin
      if (!(host_rq && (host_addr == 7'(i)))) errs++;
      lat = 1 + (i % 3);
      if (poke && i == 10) start = 1'b1;
      for (int k = 1; k < lat; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (!host_rq || host_addr != 7'(i)) errs++;
      end
      start     = 1'b0;
      host_rdy  = 1'b1;
      host_data = hdr[i];
      @(negedge clk);
      host_rdy  = 1'b0;
      host_data = 8'h00;
      if (host_rq) errs++;
      if (i < 79) @(negedge clk);
    end
    chk_eq("fetch_seq", errs, 0);
  endtask

  task automatic launch_job(input bit poke);
    n_start = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_eq("start_rq", {31'd0, host_rq}, 32'd1);
    chk_eq("start_addr", {25'd0, host_addr}, 32'd0);
    chk_eq("start_clr", {30'd0, found, exhausted}, 32'd0);
    fetch_header(poke);
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(found || exhausted) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk_eq(tag, {31'd0, found || exhausted}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic read_byte(input string tag, input logic [6:0] a, input logic [7:0] exp);
    core_addr = a;
    #1;
    chk_eq(tag, {24'd0, core_byte}, {24'd0, exp});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; host_rdy = 1'b0; host_data = 8'h00;
    core_addr = '0; hit_en = 1'b0; hit_nonce = '0; n_start = 0; last_nonce = '0;
`ifdef NONCE_SCHEDULER_LIMIT_EN
    max_tries = 32'd0;
`endif
    repeat (2) @(negedge clk);
    chk_eq("rst_outs", {27'd0, host_rq, core_start, busy, found, exhausted}, 32'd0);
    chk_eq("rst_addr", {25'd0, host_addr}, 32'd0);
    chk_eq("rst_nonce", core_nonce, 32'd0);
    chk_eq("rst_fnonce", found_nonce, 32'd0);
    rst = 1'b0;

    // Genesis header: base nonce itself wins on the first run.
    set_header(32'h7C2B_AC1D);
    hit_en = 1'b1; hit_nonce = 32'h7C2B_AC1D;
    launch_job(1'b0);
    @(negedge clk);
    chk_eq("gen_nonce", core_nonce, 32'h7C2B_AC1D);
    read_byte("gen_b0", 7'd0, 8'h01);
    read_byte("gen_b5", 7'd5, 8'h00);
    read_byte("gen_b76", 7'd76, 8'h1D);
    read_byte("gen_b77", 7'd77, 8'hAC);
    read_byte("gen_b79", 7'd79, 8'h7C);
    read_byte("gen_b80", 7'd80, 8'h00);
    chk_eq("gen_busy", {31'd0, busy}, 32'd1);
    wait_end("gen_end");
    chk_eq("gen_starts", n_start, 1);
    chk_eq("gen_fnonce", found_nonce, 32'h7C2B_AC1D);

    // Base ..19, hit at ..1D: five runs; stray starts in fetch and HASH_WAIT.
    set_header(32'h7C2B_AC19);
    launch_job(1'b1);
    begin
      int n;
      n = 0;
      while (n_start < 1 && n < 50) begin @(negedge clk); n++; end
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("hit_end");
    chk_eq("hit_starts", n_start, 5);
    chk_eq("hit_flags", {29'd0, found, exhausted, busy}, 32'd4);
    chk_eq("hit_fnonce", found_nonce, 32'h7C2B_AC1D);

    // Wrap: base FFFFFFFF misses, nonce 0 hits.
    set_header(32'hFFFF_FFFF);
    hit_nonce = 32'h0000_0000;
    launch_job(1'b0);
    wait_end("wrap_end");
    chk_eq("wrap_starts", n_start, 2);
    chk_eq("wrap_last", last_nonce, 32'h0000_0000);
    chk_eq("wrap_flags", {29'd0, found, exhausted, busy}, 32'd4);
    chk_eq("wrap_fnonce", found_nonce, 32'h0000_0000);

`ifdef NONCE_SCHEDULER_LIMIT_EN
    set_header(32'h7C2B_AC1D);
    hit_en = 1'b0;
    max_tries = 32'd3;
    launch_job(1'b0);
    wait_end("lim_end");
    chk_eq("lim_starts", n_start, 3);
    chk_eq("lim_flags", {29'd0, found, exhausted, busy}, 32'd2);
    chk_eq("lim_fnonce", found_nonce, 32'd0);
    max_tries = 32'd0;
`endif

    // Reset while waiting on the core; its late done must be ignored.
    set_header(32'h1234_5678);
    hit_en = 1'b1;
    hit_nonce = 32'h1234_5678;
    launch_job(1'b0);
    begin
      int n;
      n = 0;
      while (n_start < 1 && n < 50) begin @(negedge clk); n++; end
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk_eq("rst_late_outs", {27'd0, host_rq, core_start, busy, found, exhausted}, 32'd0);
    chk_eq("rst_late_starts", n_start, 1);
    chk_eq("rst_late_fnonce", found_nonce, 32'd0);
    chk_eq("rst_late_nonce", core_nonce, 32'd0);
    chk_eq("rst_late_addr", {25'd0, host_addr}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
